// File: rtl/mux258_bus_arbiter_pkg.sv
// Shared types and constants for the 74S258 mux-bank arbiter.
package mux258_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // Hold counter width and the legal range of the enabled window length.
  localparam int unsigned HOLD_W   = 4;
  localparam int unsigned HOLD_MIN = 1;
  localparam int unsigned HOLD_MAX = 15;

  // Winner of an IDLE-cycle arbitration. A lone requester always wins;
  // on a tie the requester named by ptr wins (ptr tied low gives req0 priority).
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic ptr);
    logic w;
    if (r0 && r1) w = ptr;
    else          w = r1;
    return w;
  endfunction

endpackage

// File: rtl/mux258_bus_arbiter_if.sv
// Request/acknowledge handshake and mux-bank control lines of the arbiter.
// master: requester/mux side, slave: the arbiter itself.
interface mux258_bus_arbiter_if;
  logic req0;
  logic req1;
  logic ack0;
  logic ack1;
  logic mux_sel;
  logic mux_enb_n;
  logic busy;
  logic owner;

  modport master (
    output req0, req1,
    input  ack0, ack1, mux_sel, mux_enb_n, busy, owner
  );

  modport slave (
    input  req0, req1,
    output ack0, ack1, mux_sel, mux_enb_n, busy, owner
  );
endinterface

// File: rtl/mux258_bus_arbiter.sv
// Two-requester arbiter owning the SEL and ENB_N lines of a 74S258 mux bank.
// Grants are HOLD_CYCLES long, never preempted, and are always followed by a
// float (TURN) cycle plus an IDLE cycle so tristate drivers never overlap.
// Optional feature: define MUX258_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise req0 wins every tie and no pointer register exists.
module mux258_bus_arbiter
  import mux258_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  mux258_bus_arbiter_if.slave  bus
);

  if (HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
    $error("mux258_bus_arbiter: HOLD_CYCLES out of range 1..15");
  end

  localparam logic [HOLD_W-1:0] CNT_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);
  // With a one-cycle window the ack must already appear in the first DRIVE cycle.
  localparam logic ACK_ON_LOAD = (HOLD_CYCLES == 1);

  state_t            state;
  logic [HOLD_W-1:0] cnt;
  logic              ack0_q;
  logic              ack1_q;
  logic              sel_q;
  logic              enb_n_q;
  logic              busy_q;
  logic              owner_q;
  logic              any_req;
  logic              win;
  logic              ptr_eff;

  assign any_req = bus.req0 | bus.req1;

`ifdef MUX258_ARB_ROUND_ROBIN_EN
  logic ptr;

  // Priority pointer: after each grant it names the requester that did not win.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (state == ST_IDLE && any_req) begin
      ptr <= ~win;
    end
  end

  always_comb ptr_eff = ptr;
`else
  // Fixed priority: tie always resolves to req0.
  always_comb ptr_eff = 1'b0;
`endif

  // Arbitration result for the current IDLE cycle.
  always_comb win = pick_winner(bus.req0, bus.req1, ptr_eff);

  // Grant FSM with inline hold counter; all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      sel_q   <= 1'b0;
      enb_n_q <= 1'b1;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          if (any_req) begin
            state   <= ST_DRIVE;
            cnt     <= CNT_LOAD;
            owner_q <= win;
            sel_q   <= win;
            enb_n_q <= 1'b0;
            busy_q  <= 1'b1;
            ack0_q  <= ACK_ON_LOAD & ~win;
            ack1_q  <= ACK_ON_LOAD &  win;
          end
        end
        ST_DRIVE: begin
          // The ack is registered one edge early so it lands on the cycle
          // whose counter value is zero, i.e. the last enabled cycle.
          if (cnt == '0) begin
            state   <= ST_TURN;
            enb_n_q <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
          end else begin
            cnt    <= cnt - CNT_ONE;
            ack0_q <= (cnt == CNT_ONE) & ~owner_q;
            ack1_q <= (cnt == CNT_ONE) &  owner_q;
          end
        end
        ST_TURN: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          enb_n_q <= 1'b1;
          busy_q  <= 1'b0;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.mux_sel   = sel_q;
  assign bus.mux_enb_n = enb_n_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mux258_bus_arbiter.sv
// Bench for mux258_bus_arbiter: a HOLD_CYCLES=3 and a HOLD_CYCLES=1 instance
// share stimulus; both are compared every cycle against a grant-timeline model.
module tb_mux258_bus_arbiter;

`ifdef MUX258_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux258_bus_arbiter_if bus3 ();
  mux258_bus_arbiter_if bus1 ();

  mux258_bus_arbiter #(.HOLD_CYCLES(3)) u_h3 (.clk(clk), .reset(rst), .bus(bus3.slave));
  mux258_bus_arbiter #(.HOLD_CYCLES(1)) u_h1 (.clk(clk), .reset(rst), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Grant timeline model: a grant decided at edge s drives the bank after
  // edges s..s+H-1, acks after s+H-1, is busy through s+H, and the next
  // decision can happen no earlier than edge s+H+2.
  int m_h[2] = '{3, 1};
  bit m_valid[2];
  int m_start[2];
  bit m_owner[2];
  int m_elig[2];
  bit m_ptr[2];
  bit prev_enb[2];
  bit prev_sel[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", nm, edge_n, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit a, input bit b);
    bit w;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_valid[d] = 1'b0;
        m_owner[d] = 1'b0;
        m_ptr[d]   = 1'b0;
        m_elig[d]  = edge_n + 1;
      end else if (edge_n >= m_elig[d] && (a || b)) begin
        w = (a && b) ? (RR ? m_ptr[d] : 1'b0) : b;
        m_owner[d] = w;
        m_ptr[d]   = ~w;
        m_valid[d] = 1'b1;
        m_start[d] = edge_n;
        m_elig[d]  = edge_n + m_h[d] + 2;
      end
    end
  endtask

  task automatic model_check();
    bit en, ak, bz;
    bit o_enb, o_sel, o_a0, o_a1, o_bz, o_own;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        o_enb = bus3.mux_enb_n; o_sel = bus3.mux_sel; o_a0 = bus3.ack0;
        o_a1 = bus3.ack1; o_bz = bus3.busy; o_own = bus3.owner;
      end else begin
        o_enb = bus1.mux_enb_n; o_sel = bus1.mux_sel; o_a0 = bus1.ack0;
        o_a1 = bus1.ack1; o_bz = bus1.busy; o_own = bus1.owner;
      end
      en = m_valid[d] && edge_n >= m_start[d] && edge_n < m_start[d] + m_h[d];
      ak = m_valid[d] && edge_n == m_start[d] + m_h[d] - 1;
      bz = m_valid[d] && edge_n >= m_start[d] && edge_n <= m_start[d] + m_h[d];
      chk($sformatf("m%0d_enb_n", d), o_enb, !en);
      chk($sformatf("m%0d_sel", d), o_sel, m_owner[d]);
      chk($sformatf("m%0d_owner", d), o_own, m_owner[d]);
      chk($sformatf("m%0d_ack0", d), o_a0, ak && !m_owner[d]);
      chk($sformatf("m%0d_ack1", d), o_a1, ak && m_owner[d]);
      chk($sformatf("m%0d_busy", d), o_bz, bz);
      if (!prev_enb[d] && !o_enb)
        chk($sformatf("m%0d_sel_stable", d), o_sel, prev_sel[d]);
      prev_enb[d] = o_enb;
      prev_sel[d] = o_sel;
    end
  endtask

  task automatic step(input bit r, input bit a, input bit b);
    rst = r;
    bus3.req0 = a; bus3.req1 = b;
    bus1.req0 = a; bus1.req1 = b;
    @(posedge clk);
    edge_n++;
    model_update(r, a, b);
    #1;
    model_check();
  endtask

  typedef struct {
    bit rst, r0, r1;
    bit enb_n, sel, ack0, ack1, busy;
  } vec_t;

  vec_t tbl[12];
  int   grants;
  int   gap;
  bit   sels[$];
  bit   exp_sel;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_elig[d] = 0; m_start[d] = 0;
      prev_enb[d] = 1; prev_sel[d] = 0;
    end
    rst = 1'b1;
    bus3.req0 = 0; bus3.req1 = 0; bus1.req0 = 0; bus1.req1 = 0;

    // Single-request walk on the HOLD=3 instance: {rst,r0,r1, enb_n,sel,ack0,ack1,busy}
    tbl[0]  = '{1,0,0, 1,0,0,0,0};
    tbl[1]  = '{0,1,0, 0,0,0,0,1};
    tbl[2]  = '{0,1,0, 0,0,0,0,1};
    tbl[3]  = '{0,1,0, 0,0,1,0,1};
    tbl[4]  = '{0,0,0, 1,0,0,0,1};
    tbl[5]  = '{0,0,0, 1,0,0,0,0};
    tbl[6]  = '{0,0,1, 0,1,0,0,1};
    tbl[7]  = '{0,0,1, 0,1,0,0,1};
    tbl[8]  = '{0,0,0, 0,1,0,1,1};
    tbl[9]  = '{0,0,0, 1,1,0,0,1};
    tbl[10] = '{0,0,0, 1,1,0,0,0};
    tbl[11] = '{1,0,0, 1,0,0,0,0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].r0, tbl[i].r1);
      chk($sformatf("tbl%0d_enb_n", i), bus3.mux_enb_n, tbl[i].enb_n);
      chk($sformatf("tbl%0d_sel", i),   bus3.mux_sel,   tbl[i].sel);
      chk($sformatf("tbl%0d_ack0", i),  bus3.ack0,      tbl[i].ack0);
      chk($sformatf("tbl%0d_ack1", i),  bus3.ack1,      tbl[i].ack1);
      chk($sformatf("tbl%0d_busy", i),  bus3.busy,      tbl[i].busy);
    end

    // Both requesters held: grant order and float gap between windows.
    step(1, 0, 0);
    sels.delete();
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      bit pe;
      pe = bus3.mux_enb_n;
      step(0, 1, 1);
      if (pe && !bus3.mux_enb_n) begin
        if (sels.size() > 0) chk("tie_float_gap", gap, 2);
        sels.push_back(bus3.mux_sel);
        gap = 0;
      end else if (bus3.mux_enb_n) begin
        gap++;
      end
    end
    chk("tie_grants", sels.size(), 4);
    for (int i = 0; i < sels.size() && i < 4; i++) begin
      exp_sel = RR ? bit'(i % 2) : 1'b0;
      chk($sformatf("tie_sel%0d", i), sels[i], exp_sel);
    end

    // Reset in the second DRIVE cycle of a req1 grant.
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("rst_mid_enb_n", bus3.mux_enb_n, 1);
    chk("rst_mid_sel",   bus3.mux_sel,   0);
    chk("rst_mid_busy",  bus3.busy,      0);
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      grants += bus3.ack1 + bus3.ack0;
    end
    chk("rst_mid_no_ack", grants, 0);

    // HOLD=1 instance: single-cycle window with coincident ack.
    step(1, 0, 0);
    step(0, 0, 1);
    chk("h1_enb_n", bus1.mux_enb_n, 0);
    chk("h1_sel",   bus1.mux_sel,   1);
    chk("h1_ack1",  bus1.ack1,      1);
    step(0, 0, 0);
    chk("h1_turn_enb_n", bus1.mux_enb_n, 1);
    chk("h1_turn_busy",  bus1.busy,      1);
    chk("h1_turn_ack1",  bus1.ack1,      0);
    step(0, 0, 0);
    chk("h1_idle_busy",  bus1.busy,      0);

    // Late req drop: held past ack but not into an IDLE decision edge.
    step(1, 0, 0);
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      bit pe;
      pe = bus3.mux_enb_n;
      step(0, i < 5, 0);
      if (pe && !bus3.mux_enb_n) grants++;
    end
    chk("late_drop_grants", grants, 1);

    // req0 held into IDLE: exactly one additional grant.
    step(1, 0, 0);
    grants = 0;
    for (int i = 0; i < 14; i++) begin
      bit pe;
      pe = bus3.mux_enb_n;
      step(0, i < 6, 0);
      if (pe && !bus3.mux_enb_n) grants++;
    end
    chk("held_into_idle_grants", grants, 2);

    // Randomized traffic with occasional reset, checked by the model.
    step(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit rr, a, b;
      rr = ($urandom_range(0, 63) == 0);
      a  = ($urandom_range(0, 2) != 0);
      b  = ($urandom_range(0, 2) != 0);
      step(rr, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
